// File: rtl/mem_port_arbiter_if.sv
// Bus bundle for mem_port_arbiter: fetch port, load/store port and the
// shared single-port memory. The arbiter uses the slave view; the core and
// memory model (or a testbench) use the master view.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  // Instruction-fetch port
  logic                  if_req;
  logic [ADDR_W-1:0]     if_addr;
  logic                  if_gnt;
  logic                  if_rvalid;
  logic [DATA_W-1:0]     if_rdata;
  // Load/store port
  logic                  ls_req;
  logic                  ls_we;
  logic [DATA_W/8-1:0]   ls_be;
  logic [ADDR_W-1:0]     ls_addr;
  logic [DATA_W-1:0]     ls_wdata;
  logic                  ls_gnt;
  logic                  ls_rvalid;
  logic [DATA_W-1:0]     ls_rdata;
  // Memory side
  logic                  mem_en;
  logic                  mem_we;
  logic [DATA_W/8-1:0]   mem_be;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic [DATA_W-1:0]     mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    output ls_gnt, ls_rvalid, ls_rdata,
    output mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output ls_req, ls_we, ls_be, ls_addr, ls_wdata,
    input  ls_gnt, ls_rvalid, ls_rdata,
    input  mem_en, mem_we, mem_be, mem_addr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and
// load/store. One transaction in flight, fixed memory read latency, LS has
// priority but may not win more than MAX_LS_STREAK times in a row while a
// fetch is waiting.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MEM_LAT       = 1,
  parameter int MAX_LS_STREAK = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  mem_port_arbiter_if.slave    bus
);

  localparam int PCNT_W = (MEM_LAT < 1) ? 1 : $clog2(MEM_LAT + 1);
  localparam int STK_W  = (MAX_LS_STREAK < 1) ? 1 : $clog2(MAX_LS_STREAK + 1);

  localparam logic [PCNT_W-1:0] PCNT_ONE = PCNT_W'(1);
  localparam logic [PCNT_W-1:0] PCNT_LAT = PCNT_W'(MEM_LAT);
  localparam logic [STK_W-1:0]  STK_MAX  = STK_W'(MAX_LS_STREAK);

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_t;

  logic [PCNT_W-1:0] r_pcnt;
  owner_t            r_owner;
  logic              r_owner_we;
  logic [STK_W-1:0]  r_streak;

  logic [PCNT_W-1:0] w_pcnt_nxt;
  owner_t            w_owner_nxt;
  logic              w_owner_we_nxt;
  logic [STK_W-1:0]  w_streak_nxt;

  logic              w_grant_ok;
  logic              w_done;
  logic              w_if_gnt;
  logic              w_ls_gnt;
  logic              w_if_rvalid;
  logic              w_ls_rvalid;
  logic [DATA_W-1:0] w_if_rdata;
  logic [DATA_W-1:0] w_ls_rdata;
  logic              w_mem_en;
  logic              w_mem_we;
  logic [DATA_W/8-1:0] w_mem_be;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  // Grants and responses are masked while reset is held so nothing leaks out
  // of the port even though requesters may keep their requests asserted.
  assign w_grant_ok = !rst && (r_pcnt <= PCNT_ONE);
  assign w_done     = !rst && (r_pcnt == PCNT_ONE);

  // Transaction state register: countdown, owner, store flag, LS streak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pcnt     <= '0;
      r_owner    <= OWN_IF;
      r_owner_we <= 1'b0;
      r_streak   <= '0;
    end else begin
      r_pcnt     <= w_pcnt_nxt;
      r_owner    <= w_owner_nxt;
      r_owner_we <= w_owner_we_nxt;
      r_streak   <= w_streak_nxt;
    end
  end

  // Arbitration, memory strobe mux, response steering and next state.
  always_comb begin
    w_if_gnt       = 1'b0;
    w_ls_gnt       = 1'b0;
    w_if_rvalid    = 1'b0;
    w_ls_rvalid    = 1'b0;
    w_if_rdata     = '0;
    w_ls_rdata     = '0;
    w_mem_en       = 1'b0;
    w_mem_we       = 1'b0;
    w_mem_be       = '0;
    w_mem_addr     = '0;
    w_mem_wdata    = '0;
    w_pcnt_nxt     = (r_pcnt != '0) ? r_pcnt - PCNT_ONE : r_pcnt;
    w_owner_nxt    = r_owner;
    w_owner_we_nxt = r_owner_we;
    w_streak_nxt   = r_streak;

    if (w_grant_ok) begin
      if (bus.ls_req && !(bus.if_req && (r_streak == STK_MAX))) begin
        w_ls_gnt = 1'b1;
      end else if (bus.if_req) begin
        w_if_gnt = 1'b1;
      end
    end

    if (w_ls_gnt) begin
      w_mem_en       = 1'b1;
      w_mem_we       = bus.ls_we;
      w_mem_be       = bus.ls_be;
      w_mem_addr     = bus.ls_addr;
      w_mem_wdata    = bus.ls_wdata;
      w_pcnt_nxt     = PCNT_LAT;
      w_owner_nxt    = OWN_LS;
      w_owner_we_nxt = bus.ls_we;
      if (!bus.if_req) begin
        w_streak_nxt = '0;
      end else if (r_streak != STK_MAX) begin
        w_streak_nxt = r_streak + STK_W'(1);
      end
    end else if (w_if_gnt) begin
      w_mem_en       = 1'b1;
      w_mem_be       = '1;
      w_mem_addr     = bus.if_addr;
      w_pcnt_nxt     = PCNT_LAT;
      w_owner_nxt    = OWN_IF;
      w_owner_we_nxt = 1'b0;
      w_streak_nxt   = '0;
    end

    // Completion cycle of the in-flight access; may coincide with a new grant.
    if (w_done) begin
      if (r_owner == OWN_IF) begin
        w_if_rvalid = 1'b1;
        w_if_rdata  = bus.mem_rdata;
      end else begin
        w_ls_rvalid = 1'b1;
        w_ls_rdata  = r_owner_we ? '0 : bus.mem_rdata;
      end
    end
  end

  assign bus.if_gnt    = w_if_gnt;
  assign bus.if_rvalid = w_if_rvalid;
  assign bus.if_rdata  = w_if_rdata;
  assign bus.ls_gnt    = w_ls_gnt;
  assign bus.ls_rvalid = w_ls_rvalid;
  assign bus.ls_rdata  = w_ls_rdata;
  assign bus.mem_en    = w_mem_en;
  assign bus.mem_we    = w_mem_we;
  assign bus.mem_be    = w_mem_be;
  assign bus.mem_addr  = w_mem_addr;
  assign bus.mem_wdata = w_mem_wdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LAT=1 driven from a
// vector table, one with MEM_LAT=3 driven by hand-written sequences. Each
// instance has a behavioural memory; response data is checked through
// per-port expectation queues.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic mem_load = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b1 ();
  mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) b3 ();

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1), .MAX_LS_STREAK(4))
    u_dut1 (.clk(clk), .rst(rst), .bus(b1));
  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3), .MAX_LS_STREAK(4))
    u_dut3 (.clk(clk), .rst(rst), .bus(b3));

  function automatic logic [31:0] init_word(input int idx);
    case (idx)
      4:       return 32'h00500093;
      5:       return 32'h00A00113;
      64:      return 32'h11223344;
      65:      return 32'hCAFE0104;
      default: return {16'hF00D, 16'(idx)};
    endcase
  endfunction

  // Behavioural memories: read data appears MEM_LAT cycles after mem_en.
  logic [31:0] mem1 [256];
  logic [31:0] mem3 [256];
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];

  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= init_word(i);
        mem3[i] <= init_word(i);
      end
    end else begin
      if (b1.mem_en && b1.mem_we)
        for (int k = 0; k < 4; k++)
          if (b1.mem_be[k]) mem1[b1.mem_addr[9:2]][8*k +: 8] <= b1.mem_wdata[8*k +: 8];
      if (b3.mem_en && b3.mem_we)
        for (int k = 0; k < 4; k++)
          if (b3.mem_be[k]) mem3[b3.mem_addr[9:2]][8*k +: 8] <= b3.mem_wdata[8*k +: 8];
    end
    pipe1    <= b1.mem_en ? mem1[b1.mem_addr[9:2]] : 32'hBAD0BAD1;
    pipe3[0] <= b3.mem_en ? mem3[b3.mem_addr[9:2]] : 32'hBAD0BAD3;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end

  assign b1.mem_rdata = pipe1;
  assign b3.mem_rdata = pipe3[2];

  logic [31:0] q1_if[$];
  logic [31:0] q1_ls[$];
  logic [31:0] q3_if[$];
  logic [31:0] q3_ls[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic unexpected(input string name);
    checks++;
    failures++;
    $display("FAIL %s: rvalid with no response expected (t=%0t)", name, $time);
  endtask

  // Response scoreboard: every rvalid pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (b1.if_rvalid) begin
      if (q1_if.size() == 0) unexpected("d1_if_rvalid");
      else chk("d1_if_rdata", b1.if_rdata, q1_if.pop_front());
    end
    if (b1.ls_rvalid) begin
      if (q1_ls.size() == 0) unexpected("d1_ls_rvalid");
      else chk("d1_ls_rdata", b1.ls_rdata, q1_ls.pop_front());
    end
    if (b3.if_rvalid) begin
      if (q3_if.size() == 0) unexpected("d3_if_rvalid");
      else chk("d3_if_rdata", b3.if_rdata, q3_if.pop_front());
    end
    if (b3.ls_rvalid) begin
      if (q3_ls.size() == 0) unexpected("d3_ls_rvalid");
      else chk("d3_ls_rdata", b3.ls_rdata, q3_ls.pop_front());
    end
  end

  typedef struct {
    logic        ir;
    logic [31:0] ia;
    logic        lr;
    logic        lwe;
    logic [3:0]  lbe;
    logic [31:0] la;
    logic [31:0] lwd;
    logic        eig;
    logic        elg;
    logic        emwe;
    logic [3:0]  embe;
    logic [31:0] ema;
    logic [31:0] emwd;
    logic        eirv;
    logic        elrv;
    logic [31:0] rsp;
  } vec_t;

  function automatic vec_t mk(
    input logic ir, input logic [31:0] ia, input logic lr, input logic lwe,
    input logic [3:0] lbe, input logic [31:0] la, input logic [31:0] lwd,
    input logic eig, input logic elg, input logic emwe, input logic [3:0] embe,
    input logic [31:0] ema, input logic [31:0] emwd,
    input logic eirv, input logic elrv, input logic [31:0] rsp);
    vec_t v;
    v.ir = ir; v.ia = ia; v.lr = lr; v.lwe = lwe; v.lbe = lbe; v.la = la; v.lwd = lwd;
    v.eig = eig; v.elg = elg; v.emwe = emwe; v.embe = embe; v.ema = ema; v.emwd = emwd;
    v.eirv = eirv; v.elrv = elrv; v.rsp = rsp;
    return v;
  endfunction

  task automatic drive1(input logic ir, input logic [31:0] ia, input logic lr,
                        input logic lwe, input logic [3:0] lbe,
                        input logic [31:0] la, input logic [31:0] lwd);
    b1.if_req = ir; b1.if_addr = ia;
    b1.ls_req = lr; b1.ls_we = lwe; b1.ls_be = lbe; b1.ls_addr = la; b1.ls_wdata = lwd;
  endtask

  task automatic drive3(input logic ir, input logic [31:0] ia, input logic lr,
                        input logic lwe, input logic [3:0] lbe,
                        input logic [31:0] la, input logic [31:0] lwd);
    b3.if_req = ir; b3.if_addr = ia;
    b3.ls_req = lr; b3.ls_we = lwe; b3.ls_be = lbe; b3.ls_addr = la; b3.ls_wdata = lwd;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_d1_gnt"},    {30'd0, b1.if_gnt, b1.ls_gnt}, 32'd0);
    chk({tag, "_d1_rvalid"}, {30'd0, b1.if_rvalid, b1.ls_rvalid}, 32'd0);
    chk({tag, "_d1_mem"},    {30'd0, b1.mem_en, b1.mem_we}, 32'd0);
    chk({tag, "_d3_gnt"},    {30'd0, b3.if_gnt, b3.ls_gnt}, 32'd0);
    chk({tag, "_d3_rvalid"}, {30'd0, b3.if_rvalid, b3.ls_rvalid}, 32'd0);
    chk({tag, "_d3_mem"},    {30'd0, b3.mem_en, b3.mem_we}, 32'd0);
  endtask

  vec_t rows [14];

  initial begin
    rows[0]  = mk(1, 32'h10, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 0, 4'hF, 32'h10,  32'h0,        0, 0, 32'h00500093);
    rows[1]  = mk(0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 4'h0, 32'h0,   32'h0,        1, 0, 32'h0);
    rows[2]  = mk(0, 32'h0,  1, 1, 4'h3, 32'h100, 32'hDEADBEEF, 0, 1, 1, 4'h3, 32'h100, 32'hDEADBEEF, 0, 0, 32'h0);
    rows[3]  = mk(0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h0);
    rows[4]  = mk(0, 32'h0,  1, 0, 4'hF, 32'h100, 32'h12345678, 0, 1, 0, 4'hF, 32'h100, 32'h12345678, 0, 0, 32'h1122BEEF);
    rows[5]  = mk(0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h0);
    rows[6]  = mk(1, 32'h14, 1, 0, 4'hF, 32'h104, 32'h0,        0, 1, 0, 4'hF, 32'h104, 32'h0,        0, 0, 32'hCAFE0104);
    rows[7]  = mk(1, 32'h14, 1, 0, 4'hF, 32'h104, 32'h0,        0, 1, 0, 4'hF, 32'h104, 32'h0,        0, 1, 32'hCAFE0104);
    rows[8]  = mk(1, 32'h14, 1, 0, 4'hF, 32'h104, 32'h0,        0, 1, 0, 4'hF, 32'h104, 32'h0,        0, 1, 32'hCAFE0104);
    rows[9]  = mk(1, 32'h14, 1, 0, 4'hF, 32'h104, 32'h0,        0, 1, 0, 4'hF, 32'h104, 32'h0,        0, 1, 32'hCAFE0104);
    rows[10] = mk(1, 32'h14, 1, 0, 4'hF, 32'h104, 32'h0,        1, 0, 0, 4'hF, 32'h14,  32'h0,        0, 1, 32'h00A00113);
    rows[11] = mk(1, 32'h18, 1, 0, 4'hF, 32'h104, 32'h0,        0, 1, 0, 4'hF, 32'h104, 32'h0,        1, 0, 32'hCAFE0104);
    rows[12] = mk(0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 1, 32'h0);
    rows[13] = mk(0, 32'h0,  0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 0, 4'h0, 32'h0,   32'h0,        0, 0, 32'h0);

    // Reset held with both requests asserted on both instances.
    drive1(1, 32'h10, 1, 0, 4'hF, 32'h100, 32'h0);
    drive3(1, 32'h10, 1, 0, 4'hF, 32'h100, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk_quiet("reset");
    end
    @(posedge clk); #1;
    mem_load = 1'b0;
    rst = 1'b0;
    drive1(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive3(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);

    // MEM_LAT=1 vector table: fetch, store, load-after-store, contention.
    for (int r = 0; r < 14; r++) begin
      @(posedge clk); #1;
      drive1(rows[r].ir, rows[r].ia, rows[r].lr, rows[r].lwe, rows[r].lbe, rows[r].la, rows[r].lwd);
      if (rows[r].eig) q1_if.push_back(rows[r].rsp);
      if (rows[r].elg) q1_ls.push_back(rows[r].rsp);
      @(negedge clk);
      chk($sformatf("row%0d_if_gnt", r),    {31'd0, b1.if_gnt},    {31'd0, rows[r].eig});
      chk($sformatf("row%0d_ls_gnt", r),    {31'd0, b1.ls_gnt},    {31'd0, rows[r].elg});
      chk($sformatf("row%0d_mem_en", r),    {31'd0, b1.mem_en},    {31'd0, rows[r].eig | rows[r].elg});
      chk($sformatf("row%0d_mem_we", r),    {31'd0, b1.mem_we},    {31'd0, rows[r].emwe});
      chk($sformatf("row%0d_mem_be", r),    {28'd0, b1.mem_be},    {28'd0, rows[r].embe});
      chk($sformatf("row%0d_mem_addr", r),  b1.mem_addr,           rows[r].ema);
      chk($sformatf("row%0d_mem_wdata", r), b1.mem_wdata,          rows[r].emwd);
      chk($sformatf("row%0d_if_rvalid", r), {31'd0, b1.if_rvalid}, {31'd0, rows[r].eirv});
      chk($sformatf("row%0d_ls_rvalid", r), {31'd0, b1.ls_rvalid}, {31'd0, rows[r].elrv});
      if (!rows[r].eirv) chk($sformatf("row%0d_if_rdata0", r), b1.if_rdata, 32'h0);
      if (!rows[r].elrv) chk($sformatf("row%0d_ls_rdata0", r), b1.ls_rdata, 32'h0);
    end

    // MEM_LAT=3: back-to-back loads, no grant while the first is in flight.
    @(posedge clk); #1;
    drive3(0, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0);
    q3_ls.push_back(32'h11223344);
    @(negedge clk);
    chk("b2b_t0_gnt",  {31'd0, b3.ls_gnt}, 32'd1);
    chk("b2b_t0_addr", b3.mem_addr, 32'h100);
    @(posedge clk); #1;
    b3.ls_addr = 32'h104;
    q3_ls.push_back(32'hCAFE0104);
    for (int k = 1; k <= 2; k++) begin
      if (k == 2) @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b_t%0d_gnt", k),    {31'd0, b3.ls_gnt},    32'd0);
      chk($sformatf("b2b_t%0d_mem_en", k), {31'd0, b3.mem_en},    32'd0);
      chk($sformatf("b2b_t%0d_rvalid", k), {31'd0, b3.ls_rvalid}, 32'd0);
    end
    @(posedge clk);
    @(negedge clk);
    chk("b2b_t3_gnt",    {31'd0, b3.ls_gnt},    32'd1);
    chk("b2b_t3_addr",   b3.mem_addr,           32'h104);
    chk("b2b_t3_rvalid", {31'd0, b3.ls_rvalid}, 32'd1);
    @(posedge clk); #1;
    b3.ls_req = 1'b0;
    for (int k = 4; k <= 6; k++) begin
      if (k > 4) @(posedge clk);
      @(negedge clk);
      chk($sformatf("b2b_t%0d_rvalid", k), {31'd0, b3.ls_rvalid}, {31'd0, k == 6});
    end

    // MEM_LAT=3: reset one cycle after a load grant drops the response.
    @(posedge clk); #1;
    drive3(0, 32'h0, 1, 0, 4'hF, 32'h100, 32'h0);
    @(negedge clk);
    chk("rst_load_gnt", {31'd0, b3.ls_gnt}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    drive1(1, 32'h10, 1, 0, 4'hF, 32'h100, 32'h0);
    drive3(1, 32'h10, 1, 0, 4'hF, 32'h100, 32'h0);
    repeat (3) begin
      @(negedge clk);
      chk_quiet("midrst");
    end
    @(posedge clk); #1;
    rst = 1'b0;
    drive1(0, 32'h0, 0, 0, 4'h0, 32'h0, 32'h0);
    drive3(1, 32'h10, 0, 0, 4'h0, 32'h0, 32'h0);
    q3_if.push_back(32'h00500093);
    @(negedge clk);
    chk("post_rst_if_gnt", {31'd0, b3.if_gnt}, 32'd1);
    chk("post_rst_ls_gnt", {31'd0, b3.ls_gnt}, 32'd0);
    chk("post_rst_addr",   b3.mem_addr,        32'h10);
    @(posedge clk); #1;
    b3.if_req = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      if (k > 1) @(posedge clk);
      @(negedge clk);
      chk($sformatf("post_rst_t%0d_ls_rvalid", k), {31'd0, b3.ls_rvalid}, 32'd0);
      chk($sformatf("post_rst_t%0d_if_rvalid", k), {31'd0, b3.if_rvalid}, {31'd0, k == 3});
    end

    chk("left_d1_if", q1_if.size(), 32'd0);
    chk("left_d1_ls", q1_ls.size(), 32'd0);
    chk("left_d3_if", q3_if.size(), 32'd0);
    chk("left_d3_ls", q3_ls.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached (checks=%0d failures=%0d)", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
